alu_src_b_stage: RTL and testbench
==================================

Name: alu_src_b_stage

Overview:
- Parametrised successor to the combinational ALU operand-B selector.
- Forms ALU operand B from one of four sources: register B, extended immediate, zero-extended shamt, or constant STEP.
- Adds EX/MEM and MEM/WB forwarding on the register path.
- Registers the result behind a 2-entry skid buffer with valid/ready handshakes, between decode/issue and the ALU.

Parameters:
- XLEN, 32, datapath width of operand and forwarding inputs.
- IMM_W, 12, raw immediate width (IMM_W <= XLEN).
- SHAMT_W, 5, raw shift-amount width (SHAMT_W <= XLEN).
- STEP, 4, constant emitted for src_sel=11 (PC increment).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  upstream operand request valid.
- in_ready  out  1  stage can accept.
- src_sel  in  2  00 reg_b, 01 imm, 10 shamt, 11 STEP.
- imm_signed  in  1  1 = sign-extend imm_raw, 0 = zero-extend.
- reg_b  in  XLEN  register-file read B.
- imm_raw  in  IMM_W  raw immediate.
- shamt_raw  in  SHAMT_W  raw shift amount.
- fwd_sel  in  2  00 none, 01 fwd_exmem, 10 fwd_memwb, 11 treated as 00.
- fwd_exmem  in  XLEN  EX/MEM result.
- fwd_memwb  in  XLEN  MEM/WB result.
- out_valid  out  1  alu_in2 valid.
- out_ready  in  1  ALU consumes.
- alu_in2  out  XLEN  selected operand B.
- out_sel  out  2  src_sel captured with the operand.
- occupancy  out  2  entries held: 0, 1 or 2.

Behaviour:
- Operand formation (combinational, at input):
  - 00: reg_b, or a forwarded value per fwd_sel. fwd_sel is ignored for other src_sel values.
  - 01: imm_raw extended to XLEN per imm_signed.
  - 10: shamt_raw zero-extended to XLEN.
  - 11: STEP truncated to XLEN.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Storage: main register (drives outputs) plus skid register. States EMPTY / ONE / FULL. occupancy = 0 / 1 / 2.
- EMPTY:
  - accept -> ONE, main loaded.
- ONE:
  - accept & !pop -> FULL, skid loaded.
  - accept & pop -> ONE, main reloaded with new operand.
  - pop & !accept -> EMPTY.
  - otherwise hold.
- FULL:
  - in_ready=0.
  - pop -> ONE, skid moves to main.
  - no pop -> hold.
- in_ready = (state != FULL), decoded from the state register only. No combinational path from out_ready to in_ready.
- out_valid = (state != EMPTY).
- Latency: 1 cycle from accept to out_valid. Sustained throughput: 1 operand per cycle.
- Ordering: strict FIFO.
- While out_valid & !out_ready, alu_in2 and out_sel hold stable.
- flush: highest priority. Next state is EMPTY, and any same-cycle accept or pop is discarded. Data registers need not clear.
- Reset (async, immediate): state EMPTY, out_valid=0, in_ready=1, alu_in2=0, out_sel=00, occupancy=0, skid data=0.
- The first accept is honoured on the first rising edge after rst deasserts.
- in_valid with in_ready=0: no state change; upstream must hold its request.

Optional Feature:
- Macro: ALU_SRC_B_FWD_EN.
- Defined: forwarding mux active as described above.
- Undefined:
  - fwd_sel, fwd_exmem and fwd_memwb ports remain but are ignored.
  - src_sel=00 always yields reg_b.
  - The forwarding mux is not synthesised.

Test Plan:
- Reset then src_sel=01, imm_raw=12'hFFC, imm_signed=1, out_ready=1 -> next cycle out_valid=1, alu_in2=32'hFFFF_FFFC, out_sel=01. Same with imm_signed=0 -> 32'h0000_0FFC.
- src_sel=10, shamt_raw=5'd31 -> alu_in2=32'd31. src_sel=11 -> alu_in2=32'd4.
- out_ready=0, three back-to-back valid requests with reg_b=1,2,3:
  - occupancy 1 then 2.
  - in_ready=0 after the second accept; third request held.
  - Release out_ready -> outputs 1,2,3 in order, none lost or duplicated.
- Define ALU_SRC_B_FWD_EN, src_sel=00, reg_b=5, fwd_exmem=7, fwd_memwb=9:
  - fwd_sel=01 -> 7; fwd_sel=10 -> 9; fwd_sel=11 -> 5.
  - Without the macro, all three cases -> 5.
- occupancy=2, assert flush together with in_valid=1 -> next cycle occupancy=0, out_valid=0, in_ready=1, flushed entries never appear.
- Assert rst mid-stream with occupancy=2 -> out_valid=0 and alu_in2=0 immediately (before the next clk edge). After deassert, a new request produces a correct result one cycle later.

Source files
------------

// File: rtl/alu_src_b_stage.sv
// ALU operand-B selector with optional EX/MEM and MEM/WB forwarding, registered behind a 2-entry skid buffer.
// Define ALU_SRC_B_FWD_EN to enable the forwarding mux on the register path.
module alu_src_b_stage #(
    parameter int XLEN    = 32,
    parameter int IMM_W   = 12,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         src_sel,
    input  logic               imm_signed,
    input  logic [XLEN-1:0]    reg_b,
    input  logic [IMM_W-1:0]   imm_raw,
    input  logic [SHAMT_W-1:0] shamt_raw,
    input  logic [1:0]         fwd_sel,
    input  logic [XLEN-1:0]    fwd_exmem,
    input  logic [XLEN-1:0]    fwd_memwb,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    alu_in2,
    output logic [1:0]         out_sel,
    output logic [1:0]         occupancy
);

    // Handshake: a beat transfers on a clock edge where valid and ready are both high.
    // in_ready depends only on the state register, never on out_ready.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] STEP_VAL = XLEN'(STEP);

    state_t            state;
    logic [XLEN-1:0]   main_data;
    logic [XLEN-1:0]   skid_data;
    logic [1:0]        main_sel;
    logic [1:0]        skid_sel;
    logic [XLEN-1:0]   imm_ext;
    logic [XLEN-1:0]   shamt_ext;
    logic [XLEN-1:0]   reg_path;
    logic [XLEN-1:0]   operand;
    logic              accept;
    logic              pop;

    assign imm_ext   = imm_signed ? XLEN'($signed(imm_raw)) : XLEN'(imm_raw);
    assign shamt_ext = XLEN'(shamt_raw);

`ifdef ALU_SRC_B_FWD_EN
    always_comb begin
        reg_path = reg_b;
        case (fwd_sel)
            2'b01:   reg_path = fwd_exmem;
            2'b10:   reg_path = fwd_memwb;
            default: reg_path = reg_b;
        endcase
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_sel, fwd_exmem, fwd_memwb};
    assign reg_path   = reg_b;
`endif

    always_comb begin
        operand = reg_path;
        case (src_sel)
            2'b00:   operand = reg_path;
            2'b01:   operand = imm_ext;
            2'b10:   operand = shamt_ext;
            default: operand = STEP_VAL;
        endcase
    end

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign alu_in2   = main_data;
    assign out_sel   = main_sel;
    assign occupancy = (state == FULL) ? 2'd2 : (state == ONE) ? 2'd1 : 2'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            main_data <= '0;
            main_sel  <= 2'b00;
            skid_data <= '0;
            skid_sel  <= 2'b00;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_data <= operand;
                        main_sel  <= src_sel;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_data <= operand;
                        main_sel  <= src_sel;
                    end else if (accept) begin
                        skid_data <= operand;
                        skid_sel  <= src_sel;
                        state     <= FULL;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    // Older entry leaves from main; the skid entry takes its place.
                    if (pop) begin
                        main_data <= skid_data;
                        main_sel  <= skid_sel;
                        state     <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_src_b_stage.sv
// Directed-vector bench for alu_src_b_stage: operand formation, skid buffering, forwarding, flush and async reset.
module tb_alu_src_b_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  src_sel = 2'b00;
    logic        imm_signed = 1'b0;
    logic [31:0] reg_b = '0;
    logic [11:0] imm_raw = '0;
    logic [4:0]  shamt_raw = '0;
    logic [1:0]  fwd_sel = 2'b00;
    logic [31:0] fwd_exmem = '0;
    logic [31:0] fwd_memwb = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] alu_in2;
    logic [1:0]  out_sel;
    logic [1:0]  occupancy;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_src_b_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .src_sel(src_sel), .imm_signed(imm_signed),
        .reg_b(reg_b), .imm_raw(imm_raw), .shamt_raw(shamt_raw),
        .fwd_sel(fwd_sel), .fwd_exmem(fwd_exmem), .fwd_memwb(fwd_memwb),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_in2(alu_in2), .out_sel(out_sel), .occupancy(occupancy)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (alu_in2 !== 32'h0) begin n_fail++; $display("FAIL reset_alu_in2 got=%h exp=0", alu_in2); end
        n_cmp++; if (out_sel !== 2'b00) begin n_fail++; $display("FAIL reset_out_sel got=%b exp=00", out_sel); end
        n_cmp++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
        rst = 1'b0;
    endtask

    task automatic test_sources();
        out_ready = 1'b1;
        in_valid = 1'b1; src_sel = 2'b01; imm_raw = 12'hFFC; imm_signed = 1'b1;
        step();
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL imm_sext_valid got=%b exp=1", out_valid); end
        n_cmp++; if (alu_in2 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL imm_sext got=%h exp=fffffffc", alu_in2); end
        n_cmp++; if (out_sel !== 2'b01) begin n_fail++; $display("FAIL imm_sext_sel got=%b exp=01", out_sel); end
        imm_signed = 1'b0;
        step();
        n_cmp++; if (alu_in2 !== 32'h0000_0FFC) begin n_fail++; $display("FAIL imm_zext got=%h exp=00000ffc", alu_in2); end
        n_cmp++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL stream_occupancy got=%0d exp=1", occupancy); end
        src_sel = 2'b10; shamt_raw = 5'd31;
        step();
        n_cmp++; if (alu_in2 !== 32'd31) begin n_fail++; $display("FAIL shamt got=%h exp=0000001f", alu_in2); end
        n_cmp++; if (out_sel !== 2'b10) begin n_fail++; $display("FAIL shamt_sel got=%b exp=10", out_sel); end
        src_sel = 2'b11;
        step();
        n_cmp++; if (alu_in2 !== 32'd4) begin n_fail++; $display("FAIL step_const got=%h exp=00000004", alu_in2); end
        n_cmp++; if (out_sel !== 2'b11) begin n_fail++; $display("FAIL step_sel got=%b exp=11", out_sel); end
        in_valid = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0; src_sel = 2'b00; fwd_sel = 2'b00;
        in_valid = 1'b1; reg_b = 32'd1;
        step();
        n_cmp++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL b2b_occ1 got=%0d exp=1", occupancy); end
        n_cmp++; if (alu_in2 !== 32'd1) begin n_fail++; $display("FAIL b2b_head1 got=%h exp=1", alu_in2); end
        reg_b = 32'd2;
        step();
        n_cmp++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL b2b_occ2 got=%0d exp=2", occupancy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready_full got=%b exp=0", in_ready); end
        reg_b = 32'd3;
        step();
        n_cmp++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL b2b_hold_occ got=%0d exp=2", occupancy); end
        n_cmp++; if (alu_in2 !== 32'd1) begin n_fail++; $display("FAIL b2b_hold_data got=%h exp=1", alu_in2); end
        out_ready = 1'b1;
        step();
        n_cmp++; if (alu_in2 !== 32'd2) begin n_fail++; $display("FAIL b2b_out2 got=%h exp=2", alu_in2); end
        n_cmp++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL b2b_occ_after_pop got=%0d exp=1", occupancy); end
        step();
        n_cmp++; if (alu_in2 !== 32'd3) begin n_fail++; $display("FAIL b2b_out3 got=%h exp=3", alu_in2); end
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_out3_valid got=%b exp=1", out_valid); end
        in_valid = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_dup got=%b exp=0", out_valid); end
    endtask

    task automatic test_forwarding();
        logic [31:0] exp_fwd [3];
`ifdef ALU_SRC_B_FWD_EN
        exp_fwd[0] = 32'd7; exp_fwd[1] = 32'd9; exp_fwd[2] = 32'd5;
`else
        exp_fwd[0] = 32'd5; exp_fwd[1] = 32'd5; exp_fwd[2] = 32'd5;
`endif
        out_ready = 1'b1; src_sel = 2'b00;
        reg_b = 32'd5; fwd_exmem = 32'd7; fwd_memwb = 32'd9;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fwd_sel = 2'(i + 1);
            step();
            n_cmp++;
            if (alu_in2 !== exp_fwd[i]) begin
                n_fail++; $display("FAIL fwd_sel_%0d got=%h exp=%h", i + 1, alu_in2, exp_fwd[i]);
            end
        end
        src_sel = 2'b01; imm_raw = 12'h005; imm_signed = 1'b1; fwd_sel = 2'b01;
        step();
        n_cmp++; if (alu_in2 !== 32'd5) begin n_fail++; $display("FAIL fwd_ignored_for_imm got=%h exp=5", alu_in2); end
        in_valid = 1'b0; fwd_sel = 2'b00;
        step();
    endtask

    task automatic test_flush();
        out_ready = 1'b0; src_sel = 2'b00; in_valid = 1'b1;
        reg_b = 32'd10;
        step();
        reg_b = 32'd11;
        step();
        n_cmp++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL flush_prefill got=%0d exp=2", occupancy); end
        flush = 1'b1; reg_b = 32'd12;
        step();
        n_cmp++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
        flush = 1'b0; out_ready = 1'b1; reg_b = 32'd13;
        step();
        n_cmp++; if (alu_in2 !== 32'd13) begin n_fail++; $display("FAIL flush_next got=%h exp=d", alu_in2); end
        in_valid = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_stale got=%b exp=0", out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; src_sel = 2'b00; in_valid = 1'b1;
        reg_b = 32'd20;
        step();
        reg_b = 32'd21;
        step();
        n_cmp++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL rst_prefill got=%0d exp=2", occupancy); end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid got=%b exp=0", out_valid); end
        n_cmp++; if (alu_in2 !== 32'h0) begin n_fail++; $display("FAIL async_rst_data got=%h exp=0", alu_in2); end
        n_cmp++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL async_rst_occ got=%0d exp=0", occupancy); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL async_rst_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1; reg_b = 32'd22;
        step();
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL post_rst_valid got=%b exp=1", out_valid); end
        n_cmp++; if (alu_in2 !== 32'd22) begin n_fail++; $display("FAIL post_rst_data got=%h exp=16", alu_in2); end
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_sources();
        test_back_to_back();
        test_forwarding();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
